// File: rtl/commit_issue_seq.sv
// Program-buffer sequencer feeding the commit unit's request/response channels.
// Issues up to DEPTH buffered instruction words in order, with single-step pause and a response watchdog.
module commit_issue_seq #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW:0]   prog_len,
  input  logic          start,
  input  logic          step_mode,
  input  logic          resume,
  output logic          req_vaild,
  input  logic          req_ready,
  output logic [31:0]   r_in,
  input  logic          rsp_vaild,
  output logic          rsp_ready,
  output logic          busy,
  output logic          paused,
  output logic          done,
  output logic          timeout_err,
  output logic [AW:0]   issue_cnt
);

  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT + 1);
  localparam int unsigned WIW = WDW + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ISSUE    = 3'd1,
    S_WAIT_RSP = 3'd2,
    S_ACK      = 3'd3,
    S_PAUSE    = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   len_q, len_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     r_in_q, r_in_d;
  logic            req_q, req_d;
  logic            rsp_ready_q, rsp_ready_d;
  logic            done_q, done_d;
  logic            terr_q, terr_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            busy_q, paused_q;

  logic [31:0]     prog_mem [DEPTH];

  logic [CW-1:0]   len_clamp_c;
  logic [31:0]     slot0_word_c;
  logic [31:0]     next_word_c;
  logic [WIW-1:0]  wd_inc_c;

  // Program buffer: writable only while idle, never cleared by reset
  always_ff @(posedge clk) begin
    if (load_en && (state_q == S_IDLE)) begin
      prog_mem[load_addr] <= load_data;
    end
  end

  // A same-cycle load to slot 0 is forwarded so the run starts with the new word
  assign slot0_word_c = (load_en && (load_addr == '0)) ? load_data : prog_mem[0];
  assign next_word_c  = prog_mem[cnt_q[AW-1:0]];
  assign len_clamp_c  = (prog_len > CW'(DEPTH)) ? CW'(DEPTH) : prog_len;
  assign wd_inc_c     = {1'b0, wd_q} + WIW'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    r_in_d      = r_in_q;
    req_d       = req_q;
    rsp_ready_d = 1'b0;
    done_d      = 1'b0;
    terr_d      = terr_q;
    wd_d        = wd_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_clamp_c == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = len_clamp_c;
            cnt_d   = '0;
            terr_d  = 1'b0;
            r_in_d  = slot0_word_c;
            req_d   = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (req_ready) begin
          req_d   = 1'b0;
          cnt_d   = cnt_q + CW'(1);
          wd_d    = '0;
          state_d = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        // A response arriving on the expiry cycle takes priority over the watchdog
        if (rsp_vaild) begin
          rsp_ready_d = 1'b1;
          state_d     = S_ACK;
        end else if (wd_inc_c == WIW'(TIMEOUT)) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_inc_c[WDW-1:0];
        end
      end
      S_ACK: begin
        if (cnt_q == len_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (step_mode) begin
          state_d = S_PAUSE;
        end else begin
          r_in_d  = next_word_c;
          req_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_PAUSE: begin
        if (resume) begin
          r_in_d  = next_word_c;
          req_d   = 1'b1;
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      r_in_q      <= '0;
      req_q       <= 1'b0;
      rsp_ready_q <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
      wd_q        <= '0;
      busy_q      <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      r_in_q      <= r_in_d;
      req_q       <= req_d;
      rsp_ready_q <= rsp_ready_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
      wd_q        <= wd_d;
      busy_q      <= (state_d != S_IDLE);
      paused_q    <= (state_d == S_PAUSE);
    end
  end

  assign req_vaild   = req_q;
  assign r_in        = r_in_q;
  assign rsp_ready   = rsp_ready_q;
  assign busy        = busy_q;
  assign paused      = paused_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign issue_cnt   = cnt_q;

endmodule

// File: tb/tb_commit_issue_seq.sv
// Directed self-checking bench for commit_issue_seq (DEPTH=8, TIMEOUT=15).
module tb_commit_issue_seq;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned AW      = 3;
  localparam int unsigned TIMEOUT = 15;

  logic          clk;
  logic          reset;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          step_mode;
  logic          resume;
  logic          req_vaild;
  logic          req_ready;
  logic [31:0]   r_in;
  logic          rsp_vaild;
  logic          rsp_ready;
  logic          busy;
  logic          paused;
  logic          done;
  logic          timeout_err;
  logic [AW:0]   issue_cnt;

  int vectors;
  int miscompares;

  logic [31:0] words [DEPTH];

  commit_issue_seq #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start),
    .step_mode(step_mode), .resume(resume), .req_vaild(req_vaild),
    .req_ready(req_ready), .r_in(r_in), .rsp_vaild(rsp_vaild),
    .rsp_ready(rsp_ready), .busy(busy), .paused(paused), .done(done),
    .timeout_err(timeout_err), .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick;
    load_en = 1'b0;
  endtask

  task automatic test_reset;
    logic [41:0] obs;
    tick;
    obs = {req_vaild, rsp_ready, done, timeout_err, busy, paused, issue_cnt, r_in};
    vectors++;
    if (obs !== 42'h0) begin
      miscompares++;
      $display("FAIL reset_state: got %h want 0", obs);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] req_mask, done_mask;
    int nreq;
    logic order_ok, busy_at_done;
    req_ready = 1'b1; rsp_vaild = 1'b1; prog_len = 4'd3;
    start = 1'b1; tick; start = 1'b0;
    req_mask = '0; done_mask = '0; nreq = 0; order_ok = 1'b1; busy_at_done = 1'bx;
    for (int c = 1; c <= 14; c++) begin
      req_mask[c]  = req_vaild;
      done_mask[c] = done;
      if (req_vaild && req_ready) begin
        if (nreq >= 3 || r_in !== words[nreq]) order_ok = 1'b0;
        nreq++;
      end
      if (c == 10) busy_at_done = busy;
      tick;
    end
    vectors++;
    if (req_mask !== 16'h0092) begin
      miscompares++;
      $display("FAIL b2b_req_cycles: got %h want 0092", req_mask);
    end
    vectors++;
    if (done_mask !== 16'h0400) begin
      miscompares++;
      $display("FAIL b2b_done_cycle: got %h want 0400", done_mask);
    end
    vectors++;
    if (nreq != 3) begin
      miscompares++;
      $display("FAIL b2b_req_count: got %0d want 3", nreq);
    end
    vectors++;
    if (order_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_slot_order: got %b want 1", order_ok);
    end
    vectors++;
    if (busy_at_done !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_busy_at_done: got %b want 0", busy_at_done);
    end
    vectors++;
    if (issue_cnt !== 4'd3) begin
      miscompares++;
      $display("FAIL b2b_issue_cnt: got %0d want 3", issue_cnt);
    end
    req_ready = 1'b0; rsp_vaild = 1'b0;
    tick;
  endtask

  task automatic test_ready_delay;
    req_ready = 1'b0; rsp_vaild = 1'b0; prog_len = 4'd1;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      vectors++;
      if ({req_vaild, r_in, issue_cnt} !== {1'b1, words[0], 4'd0}) begin
        miscompares++;
        $display("FAIL hold_c%0d: got req=%b r_in=%h cnt=%0d want req=1 r_in=%h cnt=0",
                 c, req_vaild, r_in, issue_cnt, words[0]);
      end
      tick;
    end
    // cycle 6: ready arrives, handshake at the next edge
    req_ready = 1'b1; tick; req_ready = 1'b0;
    vectors++;
    if ({req_vaild, issue_cnt} !== {1'b0, 4'd1}) begin
      miscompares++;
      $display("FAIL hold_handshake: got req=%b cnt=%0d want req=0 cnt=1", req_vaild, issue_cnt);
    end
    rsp_vaild = 1'b1; tick; rsp_vaild = 1'b0;
    vectors++;
    if (rsp_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_rsp_ready: got %b want 1", rsp_ready);
    end
    tick;
    vectors++;
    if ({rsp_ready, done} !== 2'b01) begin
      miscompares++;
      $display("FAIL hold_done: got rsp_ready=%b done=%b want 0 1", rsp_ready, done);
    end
    tick;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_done_pulse: got %b want 0", done);
    end
  endtask

  task automatic test_step_mode;
    logic seen_req, seen_done;
    step_mode = 1'b1; req_ready = 1'b1; rsp_vaild = 1'b1; prog_len = 4'd2;
    start = 1'b1; tick; start = 1'b0;
    tick; tick; tick;
    vectors++;
    if ({paused, busy, issue_cnt} !== {1'b1, 1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL step_paused: got paused=%b busy=%b cnt=%0d want 1 1 1", paused, busy, issue_cnt);
    end
    seen_req = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) begin
        load_en = 1'b1; load_addr = 3'd1; load_data = 32'hDEAD_BEEF;
        start = 1'b1; prog_len = 4'd1;
      end
      tick;
      load_en = 1'b0; start = 1'b0;
      seen_req  = seen_req | req_vaild;
      seen_done = seen_done | done;
    end
    vectors++;
    if ({seen_req, seen_done, paused} !== 3'b001) begin
      miscompares++;
      $display("FAIL step_hold: got req_seen=%b done_seen=%b paused=%b want 0 0 1", seen_req, seen_done, paused);
    end
    resume = 1'b1; tick; resume = 1'b0;
    vectors++;
    if ({req_vaild, paused, r_in} !== {1'b1, 1'b0, words[1]}) begin
      miscompares++;
      $display("FAIL step_resume: got req=%b paused=%b r_in=%h want 1 0 %h", req_vaild, paused, r_in, words[1]);
    end
    tick; tick; tick;
    vectors++;
    if ({done, busy, issue_cnt} !== {1'b1, 1'b0, 4'd2}) begin
      miscompares++;
      $display("FAIL step_done: got done=%b busy=%b cnt=%0d want 1 0 2", done, busy, issue_cnt);
    end
    step_mode = 1'b0; req_ready = 1'b0; rsp_vaild = 1'b0;
    tick;
  endtask

  task automatic test_timeout;
    logic seen_terr, seen_done;
    req_ready = 1'b1; rsp_vaild = 1'b0; prog_len = 4'd1;
    start = 1'b1; tick; start = 1'b0;
    tick; req_ready = 1'b0;
    seen_terr = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 14; c++) begin
      tick;
      seen_terr = seen_terr | timeout_err;
      seen_done = seen_done | done;
    end
    vectors++;
    if ({seen_terr, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL wd_early: got terr_seen=%b busy=%b want 0 1", seen_terr, busy);
    end
    tick;
    vectors++;
    if ({timeout_err, busy, done, seen_done} !== 4'b1000) begin
      miscompares++;
      $display("FAIL wd_expire: got terr=%b busy=%b done=%b done_seen=%b want 1 0 0 0",
               timeout_err, busy, done, seen_done);
    end
    tick;
    req_ready = 1'b1; start = 1'b1; tick; start = 1'b0;
    vectors++;
    if ({timeout_err, req_vaild} !== 2'b01) begin
      miscompares++;
      $display("FAIL wd_clear_on_start: got terr=%b req=%b want 0 1", timeout_err, req_vaild);
    end
    tick; req_ready = 1'b0;
    for (int c = 0; c < 14; c++) tick;
    rsp_vaild = 1'b1; tick; rsp_vaild = 1'b0;
    vectors++;
    if ({rsp_ready, timeout_err} !== 2'b10) begin
      miscompares++;
      $display("FAIL wd_rsp_wins: got rsp_ready=%b terr=%b want 1 0", rsp_ready, timeout_err);
    end
    tick;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL wd_rsp_done: got %b want 1", done);
    end
    tick;
  endtask

  task automatic test_len_bounds;
    int nreq;
    logic order_ok, done_seen;
    prog_len = 4'd0; start = 1'b1; tick; start = 1'b0;
    vectors++;
    if ({done, req_vaild, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL len0: got done=%b req=%b busy=%b want 1 0 0", done, req_vaild, busy);
    end
    tick;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL len0_pulse: got %b want 0", done);
    end
    req_ready = 1'b1; rsp_vaild = 1'b1; prog_len = 4'd15;
    start = 1'b1; tick; start = 1'b0;
    nreq = 0; order_ok = 1'b1; done_seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (req_vaild && req_ready) begin
        if (nreq >= DEPTH || r_in !== words[nreq]) order_ok = 1'b0;
        nreq++;
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      tick;
    end
    vectors++;
    if ({done_seen, order_ok} !== 2'b11 || nreq != 8) begin
      miscompares++;
      $display("FAIL len_clamp: got done=%b order=%b nreq=%0d want 1 1 8", done_seen, order_ok, nreq);
    end
    vectors++;
    if (issue_cnt !== 4'd8) begin
      miscompares++;
      $display("FAIL len_clamp_cnt: got %0d want 8", issue_cnt);
    end
    req_ready = 1'b0; rsp_vaild = 1'b0;
    tick;
  endtask

  task automatic test_reset_midrun;
    logic [41:0] obs;
    req_ready = 1'b1; rsp_vaild = 1'b0; prog_len = 4'd2;
    start = 1'b1; tick; start = 1'b0;
    tick; req_ready = 1'b0;
    vectors++;
    if ({busy, issue_cnt} !== {1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL midrun_wait: got busy=%b cnt=%0d want 1 1", busy, issue_cnt);
    end
    reset = 1'b0; tick;
    obs = {req_vaild, rsp_ready, done, timeout_err, busy, paused, issue_cnt, r_in};
    vectors++;
    if (obs !== 42'h0) begin
      miscompares++;
      $display("FAIL midrun_reset: got %h want 0", obs);
    end
    reset = 1'b1; tick;
    req_ready = 1'b1; rsp_vaild = 1'b1; prog_len = 4'd1;
    start = 1'b1; tick; start = 1'b0;
    vectors++;
    if ({req_vaild, r_in} !== {1'b1, words[0]}) begin
      miscompares++;
      $display("FAIL buffer_kept: got req=%b r_in=%h want 1 %h", req_vaild, r_in, words[0]);
    end
    tick; tick; tick;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_rerun_done: got %b want 1", done);
    end
    req_ready = 1'b0; rsp_vaild = 1'b0;
    tick;
  endtask

  task automatic test_load_start;
    load_en = 1'b1; load_addr = 3'd0; load_data = 32'hCAFE_F00B;
    start = 1'b1; prog_len = 4'd1;
    tick;
    load_en = 1'b0; start = 1'b0;
    vectors++;
    if ({req_vaild, r_in} !== {1'b1, 32'hCAFE_F00B}) begin
      miscompares++;
      $display("FAIL load_start_fwd: got req=%b r_in=%h want 1 cafef00b", req_vaild, r_in);
    end
    req_ready = 1'b1; rsp_vaild = 1'b1;
    tick; tick; tick;
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL load_start_done: got %b want 1", done);
    end
    req_ready = 1'b0; rsp_vaild = 1'b0;
    tick;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    words[0] = 32'h02A5_490B; words[1] = 32'h4003_FF4B;
    words[2] = 32'h0000_700B; words[3] = 32'h1234_560B;
    words[4] = 32'h89AB_CD0B; words[5] = 32'h5555_AA0B;
    words[6] = 32'h0F0F_F00B; words[7] = 32'h7777_000B;
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    prog_len = '0; start = 1'b0; step_mode = 1'b0; resume = 1'b0;
    req_ready = 1'b0; rsp_vaild = 1'b0;
    tick;
    test_reset;
    reset = 1'b1;
    tick;
    for (int i = 0; i < DEPTH; i++) load_word(3'(i), words[i]);
    test_back_to_back;
    test_ready_delay;
    test_step_mode;
    test_timeout;
    test_len_bounds;
    test_reset_midrun;
    test_load_start;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
